// File: rtl/window_feed_ctrl.sv
// window_feed_ctrl
//   Sequences one RGB frame into the three-channel window line-buffer.
//   Walks a raster over the padded frame. Border positions write zero pixels
//   without touching the source. Interior positions take pixels from an
//   upstream valid/ready stream. Windows reported back by the line-buffer are
//   counted, and frame_done pulses once the last window has been seen.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   start                 one-cycle frame request, honoured only when idle
//   stall                 downstream hold; freezes emission and raster counters
//   src_valid/src_ready   upstream handshake (src_ready is combinational)
//   src_pixelR/G/B        signed upstream pixel channels
//   pixelR/G/B, wr_en     registered pixel data and write strobe to line-buffer
//   win_valid             one pulse per window produced by the line-buffer
//   busy                  high while feeding or draining
//   frame_done            one-cycle pulse at frame completion
//   row, col              current padded-raster position
//   win_count             windows seen in the current frame (saturating)
module window_feed_ctrl #(
   parameter  int image_size  = 224,
   parameter  int window_size = 3,
   parameter  int padding     = 1,
   parameter  int bitsize     = 14,
   localparam int P           = image_size + 2 * padding,
   localparam int NUM_WIN     = (P - window_size + 1) * (P - window_size + 1),
   localparam int CW          = $clog2(P),
   localparam int WW          = $clog2(NUM_WIN + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stall,
   input  logic                 src_valid,
   output logic                 src_ready,
   input  logic signed [bitsize:0] src_pixelR,
   input  logic signed [bitsize:0] src_pixelG,
   input  logic signed [bitsize:0] src_pixelB,
   output logic signed [bitsize:0] pixelR,
   output logic signed [bitsize:0] pixelG,
   output logic signed [bitsize:0] pixelB,
   output logic                 wr_en,
   input  logic                 win_valid,
   output logic                 busy,
   output logic                 frame_done,
   output logic [CW-1:0]        row,
   output logic [CW-1:0]        col,
   output logic [WW-1:0]        win_count
);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

   localparam logic [CW-1:0] LAST    = CW'(P - 1);
   localparam logic [CW-1:0] LO      = CW'(padding);
   localparam logic [CW-1:0] HI      = CW'(P - padding);
   localparam logic [WW-1:0] WIN_MAX = WW'(NUM_WIN);

   state_t state, state_d;

   logic                   border;
   logic                   last_pos;
   logic                   emit;
   logic                   win_inc;
   logic [CW-1:0]          row_d, col_d;
   logic [WW-1:0]          win_count_d;
   logic signed [bitsize:0] pixelR_d, pixelG_d, pixelB_d;
   logic                   wr_en_d;
   logic                   busy_d;
   logic                   frame_done_d;

   always_comb begin
      border    = (row < LO) || (row >= HI) || (col < LO) || (col >= HI);
      last_pos  = (row == LAST) && (col == LAST);
      src_ready = (state == FEED) && !stall && !border;
      // Border positions always emit; interior positions emit only on accept.
      emit      = (state == FEED) && !stall && (border || src_valid);
      // Window counting follows the line-buffer, independent of stall.
      win_inc   = win_valid && ((state == FEED) || (state == DRAIN)) &&
                  (win_count != WIN_MAX);

      state_d     = state;
      row_d       = row;
      col_d       = col;
      win_count_d = win_inc ? win_count + 1'b1 : win_count;
      pixelR_d    = pixelR;
      pixelG_d    = pixelG;
      pixelB_d    = pixelB;
      wr_en_d     = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_d     = FEED;
               row_d       = '0;
               col_d       = '0;
               win_count_d = '0;
            end
         end
         FEED: begin
            if (emit) begin
               wr_en_d = 1'b1;
               if (border) begin
                  pixelR_d = '0;
                  pixelG_d = '0;
                  pixelB_d = '0;
               end else begin
                  pixelR_d = src_pixelR;
                  pixelG_d = src_pixelG;
                  pixelB_d = src_pixelB;
               end
               // The final position leaves row/col parked at the last pixel.
               if (last_pos) begin
                  state_d = DRAIN;
               end else if (col == LAST) begin
                  col_d = '0;
                  row_d = row + 1'b1;
               end else begin
                  col_d = col + 1'b1;
               end
            end
         end
         DRAIN: begin
            // Uses the post-increment count so the landing pulse finishes the frame.
            if (win_count_d == WIN_MAX) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d       = (state_d == FEED) || (state_d == DRAIN);
      frame_done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         row        <= '0;
         col        <= '0;
         win_count  <= '0;
         pixelR     <= '0;
         pixelG     <= '0;
         pixelB     <= '0;
         wr_en      <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_d;
         row        <= row_d;
         col        <= col_d;
         win_count  <= win_count_d;
         pixelR     <= pixelR_d;
         pixelG     <= pixelG_d;
         pixelB     <= pixelB_d;
         wr_en      <= wr_en_d;
         busy       <= busy_d;
         frame_done <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_window_feed_ctrl.sv
// tb_window_feed_ctrl
//   Drives a small (4x4, padded to 6x6) and a default-size instance of
//   window_feed_ctrl with shared stimulus and compares every cycle against a
//   frame-level reference model (write index -> padded position -> expected
//   pixel).
module tb_window_feed_ctrl;
   localparam int BS = 14;

   typedef enum {M_IDLE, M_FEED, M_DRAIN, M_DONE} mph_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start_s, start_b, stall, src_valid, win_valid;
   logic signed [BS:0] src_r, src_g, src_b;

   logic rdy_s, wr_s, busy_s, done_s;
   logic signed [BS:0] pr_s, pg_s, pb_s;
   logic [2:0] row_s, col_s;
   logic [4:0] wc_s;

   logic rdy_b, wr_b, busy_b, done_b;
   logic signed [BS:0] pr_b, pg_b, pb_b;
   logic [7:0] row_b, col_b;
   logic [15:0] wc_b;

   window_feed_ctrl #(.image_size(4), .window_size(3), .padding(1), .bitsize(BS)) dut_s (
      .clk(clk), .rst(rst), .start(start_s), .stall(stall),
      .src_valid(src_valid), .src_ready(rdy_s),
      .src_pixelR(src_r), .src_pixelG(src_g), .src_pixelB(src_b),
      .pixelR(pr_s), .pixelG(pg_s), .pixelB(pb_s), .wr_en(wr_s),
      .win_valid(win_valid), .busy(busy_s), .frame_done(done_s),
      .row(row_s), .col(col_s), .win_count(wc_s));

   window_feed_ctrl #(.image_size(224), .window_size(3), .padding(1), .bitsize(BS)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .stall(stall),
      .src_valid(src_valid), .src_ready(rdy_b),
      .src_pixelR(src_r), .src_pixelG(src_g), .src_pixelB(src_b),
      .pixelR(pr_b), .pixelG(pg_b), .pixelB(pb_b), .wr_en(wr_b),
      .win_valid(win_valid), .busy(busy_b), .frame_done(done_b),
      .row(row_b), .col(col_b), .win_count(wc_b));

   // Observed outputs of the instance under test.
   logic sel;
   logic o_rdy, o_wr, o_busy, o_done;
   logic [BS:0] o_r, o_g, o_b;
   logic [31:0] o_row, o_col, o_wc;
   assign o_rdy  = sel ? rdy_b  : rdy_s;
   assign o_wr   = sel ? wr_b   : wr_s;
   assign o_busy = sel ? busy_b : busy_s;
   assign o_done = sel ? done_b : done_s;
   assign o_r    = sel ? pr_b   : pr_s;
   assign o_g    = sel ? pg_b   : pg_s;
   assign o_b    = sel ? pb_b   : pb_s;
   assign o_row  = sel ? 32'(row_b) : 32'(row_s);
   assign o_col  = sel ? 32'(col_b) : 32'(col_s);
   assign o_wc   = sel ? 32'(wc_b)  : 32'(wc_s);

   // Reference model state.
   mph_t ph;
   int Pm, IMGm, Nm;
   int mw, mwc, acc;
   logic [BS:0] lr, lg, lb;
   logic [BS:0] mem [50176];
   int rdy_cnt, wr_cnt, done_cnt;
   int checks, failures;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_border(int p);
      int r, c;
      r = p / Pm;
      c = p % Pm;
      return (r < 1) || (r >= Pm - 1) || (c < 1) || (c >= Pm - 1);
   endfunction

   function automatic int src_index(int p);
      return (p / Pm - 1) * IMGm + (p % Pm - 1);
   endfunction

   task automatic drive_src();
      logic [BS:0] v;
      v = (acc < IMGm * IMGm) ? mem[acc] : '0;
      src_r = v;
      src_g = v ^ 15'h2AAA;
      src_b = ~v;
   endtask

   // One clock: check src_ready before the edge, advance the model on the
   // edge, then check all registered outputs 1 time unit later.
   task automatic tick();
      logic exp_rdy, exp_wr, hs, start_cur;
      logic [BS:0] v;
      int pos;
      #1;
      exp_rdy = (ph == M_FEED) && !stall && !rst && !is_border(mw);
      chk("src_ready", 64'(o_rdy), 64'(exp_rdy));
      hs = src_valid && (o_rdy === 1'b1);
      if (o_rdy === 1'b1) rdy_cnt++;
      start_cur = sel ? start_b : start_s;
      @(posedge clk);
      exp_wr = 1'b0;
      if (rst) begin
         ph = M_IDLE; mw = 0; mwc = 0; lr = '0; lg = '0; lb = '0;
      end else begin
         case (ph)
            M_IDLE: if (start_cur) begin ph = M_FEED; mw = 0; mwc = 0; end
            M_FEED: begin
               if (win_valid && mwc < Nm) mwc++;
               if (!stall && (is_border(mw) || src_valid)) begin
                  exp_wr = 1'b1;
                  if (is_border(mw)) begin
                     lr = '0; lg = '0; lb = '0;
                  end else begin
                     v = mem[src_index(mw)];
                     lr = v; lg = v ^ 15'h2AAA; lb = ~v;
                  end
                  mw++;
                  if (mw == Pm * Pm) ph = M_DRAIN;
               end
            end
            M_DRAIN: begin
               if (win_valid && mwc < Nm) mwc++;
               if (mwc == Nm) ph = M_DONE;
            end
            default: ph = M_IDLE;
         endcase
      end
      #1;
      if (hs) acc++;
      drive_src();
      pos = (mw < Pm * Pm) ? mw : Pm * Pm - 1;
      chk("wr_en", 64'(o_wr), 64'(exp_wr));
      chk("pixelR", 64'(o_r), 64'(lr));
      chk("pixelG", 64'(o_g), 64'(lg));
      chk("pixelB", 64'(o_b), 64'(lb));
      chk("busy", 64'(o_busy), 64'((ph == M_FEED) || (ph == M_DRAIN)));
      chk("frame_done", 64'(o_done), 64'(ph == M_DONE));
      chk("win_count", 64'(o_wc), 64'(mwc));
      chk("row", 64'(o_row), 64'(pos / Pm));
      chk("col", 64'(o_col), 64'(pos % Pm));
      if (o_wr === 1'b1) wr_cnt++;
      if (o_done === 1'b1) done_cnt++;
   endtask

   // vmode: 0 src_valid held high, 1 toggling 1,0, 2 random stall/valid/windows.
   task automatic run_frame(input bit big, input int vmode, input int stall_at,
                            input int stall_len, input int restart_at, input int abort_at);
      int cyc, dcnt, wv_sent, stall_left;
      bit stalled, restarted, tog;
      cyc = 0; dcnt = 0; wv_sent = 0; stall_left = 0;
      stalled = 1'b0; restarted = 1'b0; tog = 1'b0;
      sel  = big;
      Pm   = big ? 226 : 6;
      IMGm = Pm - 2;
      Nm   = IMGm * IMGm;
      for (int k = 0; k < IMGm * IMGm; k++)
         mem[k] = (vmode == 2) ? 15'($urandom) : 15'(k + 1);
      acc = 0; rdy_cnt = 0; wr_cnt = 0; done_cnt = 0;
      stall = 1'b0; src_valid = 1'b0; win_valid = 1'b0;
      drive_src();
      if (big) start_b = 1'b1; else start_s = 1'b1;
      tick();
      start_b = 1'b0; start_s = 1'b0;
      while (ph != M_IDLE && cyc < 100000) begin
         if (stall_at >= 0 && !stalled && mw == stall_at) begin
            stalled = 1'b1; stall_left = stall_len;
         end
         if (vmode == 2) stall = ($urandom_range(31) == 0);
         else            stall = (stall_left > 0);
         if (stall_left > 0) stall_left--;
         case (vmode)
            0:       src_valid = 1'b1;
            1:       begin src_valid = !tog; tog = !tog; end
            default: src_valid = ($urandom_range(15) != 0);
         endcase
         if (vmode == 2)
            win_valid = ((ph == M_FEED) || (ph == M_DRAIN)) && !stall &&
                        (wv_sent < Nm) && ($urandom_range(7) != 0);
         else
            win_valid = ((ph == M_FEED) && !stall && (wv_sent < Nm - 1) && (cyc % 2 == 0)) ||
                        ((ph == M_DRAIN) && (dcnt == 3) && (wv_sent == Nm - 1));
         if (win_valid) wv_sent++;
         if (ph == M_DRAIN) dcnt++;
         if (restart_at >= 0 && !restarted && mw == restart_at) begin
            restarted = 1'b1;
            if (big) start_b = 1'b1; else start_s = 1'b1;
         end
         tick();
         start_s = 1'b0; start_b = 1'b0;
         cyc++;
         if (abort_at >= 0 && mw == abort_at && ph == M_FEED) begin
            stall = 1'b0; src_valid = 1'b0; win_valid = 1'b0;
            rst = 1'b1;
            #1;
            chk("rst_wr_en", 64'(o_wr), 64'(0));
            chk("rst_busy", 64'(o_busy), 64'(0));
            chk("rst_frame_done", 64'(o_done), 64'(0));
            chk("rst_pixelR", 64'(o_r), 64'(0));
            chk("rst_pixelG", 64'(o_g), 64'(0));
            chk("rst_pixelB", 64'(o_b), 64'(0));
            chk("rst_row", 64'(o_row), 64'(0));
            chk("rst_col", 64'(o_col), 64'(0));
            chk("rst_win_count", 64'(o_wc), 64'(0));
            chk("rst_src_ready", 64'(o_rdy), 64'(0));
            tick();
            rst = 1'b0;
            tick();
            chk("abort_no_frame_done", 64'(done_cnt), 64'(0));
            return;
         end
      end
      stall = 1'b0; src_valid = 1'b0; win_valid = 1'b0;
      chk("frame_writes", 64'(wr_cnt), 64'(Pm * Pm));
      chk("frame_done_pulses", 64'(done_cnt), 64'(1));
      if (vmode == 0) chk("src_ready_cycles", 64'(rdy_cnt), 64'(IMGm * IMGm));
      // A window report after completion must not disturb the count.
      win_valid = 1'b1;
      tick();
      win_valid = 1'b0;
      tick();
   endtask

   initial begin
      checks = 0; failures = 0;
      ph = M_IDLE; mw = 0; mwc = 0; acc = 0;
      lr = '0; lg = '0; lb = '0;
      sel = 1'b0; Pm = 6; IMGm = 4; Nm = 16;
      rdy_cnt = 0; wr_cnt = 0; done_cnt = 0;
      rst = 1'b1; start_s = 1'b0; start_b = 1'b0;
      stall = 1'b0; src_valid = 1'b0; win_valid = 1'b0;
      src_r = '0; src_g = '0; src_b = '0;

      tick();
      tick();
      rst = 1'b0;
      tick();

      run_frame(1'b0, 0, -1, 0, -1, -1);   // held valid, full drain sequence
      run_frame(1'b0, 1, -1, 0, -1, -1);   // toggling valid
      run_frame(1'b0, 0, 10, 5, -1, -1);   // 5-cycle stall after write 10
      run_frame(1'b0, 0, -1, 0, 6, 20);    // ignored restart, abort at write 20

      // Start and reset together: reset wins and the block stays idle.
      rst = 1'b1; start_s = 1'b1;
      tick();
      start_s = 1'b0; rst = 1'b0;
      tick();

      run_frame(1'b0, 2, -1, 0, -1, -1);   // fresh small frame, random
      run_frame(1'b1, 2, -1, 0, -1, -1);   // default size, random

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
